// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double dabble.
// Start/busy/done handshake; an illegal input digit is reported through err.
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ADJ, DONE} state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd;
    logic [BIN_W-1:0]   bin;
    logic [CNT_W-1:0]   cnt;
    logic               bad;
    logic               in_bad;
    logic [BCD_W-1:0]   bcd_adj;

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
        end
    end

    // Undo the +3 correction of forward double dabble, independently per nibble.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd8) bcd_adj[4*i +: 4] = bcd[4*i +: 4] - 4'd3;
        end
    end

    // The illegal-digit flag is kept internally so err only moves on a done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bcd     <= '0;
            bin     <= '0;
            cnt     <= '0;
            bad     <= 1'b0;
            bin_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bcd   <= bcd_in;
                        bin   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        bad   <= in_bad;
                        state <= in_bad ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd, bin} >> 1;
                    cnt        <= cnt + CNT_W'(1);
                    state      <= ADJ;
                end
                ADJ: begin
                    bcd   <= bcd_adj;
                    state <= (cnt == CNT_W'(BIN_W)) ? DONE : SHIFT;
                end
                DONE: begin
                    bin_out <= bad ? '0 : bin;
                    err     <= bad;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: stimulus pushes expected results, a monitor
// pops and compares them whenever done pulses.
module tb_bcd_to_bin;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bcd_in;
    logic [13:0] bin_out;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [13:0] bin;
        logic        err;
        int          start_cyc;
        int          lat_min;
        int          lat_max;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   done_count = 0;

    bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_output(input string name, input logic [13:0] exp_bin,
                                input logic exp_busy, input logic exp_done, input logic exp_err);
        check({name, ".bin_out"}, 32'(bin_out), 32'(exp_bin));
        check({name, ".busy"},    32'(busy),    32'(exp_busy));
        check({name, ".done"},    32'(done),    32'(exp_done));
        check({name, ".err"},     32'(err),     32'(exp_err));
    endtask

    // Monitor: each done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done with bin_out=%0d, expected no done", bin_out);
            end else begin
                int lat;
                e   = sb.pop_front();
                lat = cycle - e.start_cyc;
                check("done.bin_out", 32'(bin_out), 32'(e.bin));
                check("done.err",     32'(err),     32'(e.err));
                check("done.busy",    32'(busy),    32'(0));
                checks++;
                if (lat < e.lat_min || lat > e.lat_max) begin
                    errors++;
                    $display("[TB] FAIL latency: got %0d cycles, expected %0d..%0d", lat, e.lat_min, e.lat_max);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("wait_idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic wait_done(output bit seen);
        int n = 0;
        seen = 0;
        while (n < 200 && !seen) begin
            @(negedge clk);
            if (done) seen = 1;
            n++;
        end
        if (!seen) check("wait_done_timeout", 32'(0), 32'(1));
    endtask

    task automatic push_exp(input logic [13:0] exp_bin, input logic exp_err);
        exp_t e;
        e.bin       = exp_bin;
        e.err       = exp_err;
        e.start_cyc = cycle;
        e.lat_min   = exp_err ? 1 : 29;
        e.lat_max   = exp_err ? 2 : 29;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [15:0] bcd, input logic [13:0] exp_bin,
                                  input logic exp_err, input bit expect_done);
        wait_idle();
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_done) push_exp(exp_bin, exp_err);
    endtask

    initial begin
        bit seen;
        int d1;
        int d2;
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 16'h0000;
        repeat (3) @(negedge clk);
        check_output("reset", 14'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        apply_stimulus(16'h9999, 14'd9999, 1'b0, 1'b1);
        apply_stimulus(16'h1234, 14'd1234, 1'b0, 1'b1);
        apply_stimulus(16'h0000, 14'd0,    1'b0, 1'b1);
        apply_stimulus(16'h12A4, 14'd0,    1'b1, 1'b1);
        apply_stimulus(16'h0042, 14'd42,   1'b0, 1'b1);

        // A start pulse while busy must be ignored.
        apply_stimulus(16'h0500, 14'd500, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        bcd_in = 16'h0777;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check_output("held_500", 14'd500, 1'b0, 1'b0, 1'b0);

        // Reset mid-conversion abandons the result.
        apply_stimulus(16'h4321, 14'd0, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("abort_reset", 14'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(16'h0001, 14'd1, 1'b0, 1'b1);

        // Start held high across two back-to-back conversions.
        wait_idle();
        bcd_in = 16'h0010;
        start  = 1'b1;
        @(posedge clk);
        #1;
        push_exp(14'd10, 1'b0);
        wait_done(seen);
        d1 = cycle;
        bcd_in = 16'h0020;
        @(posedge clk);
        #1;
        push_exp(14'd20, 1'b0);
        wait_done(seen);
        d2 = cycle;
        start = 1'b0;
        check("done_spacing", 32'(d2 - d1), 32'd30);

        wait_idle();
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("done_count", 32'(done_count), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
